// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
// The control-bit layout is common to every stage register in the pipeline.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int DATA_W_DEF = 101;
  localparam int CTRL_W_DEF = 7;

  localparam int CTRL_PCSRC    = 0;
  localparam int CTRL_JTOPC    = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_SPARE    = 6;

  function automatic logic [1:0] occ_of(input stage_state_e s);
    case (s)
      EMPTY:   return OCC_EMPTY;
      ONE:     return OCC_ONE;
      default: return OCC_FULL;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Also used for the pipeline stall counters.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(negedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble and a saturating count of flushes that discarded live beats.
//
// state | meaning
// EMPTY | no beat held, out_valid low
// ONE   | main register holds the head beat
// FULL  | main holds head, skid holds the next beat; in_ready low (SKID = 1 only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_state_e      state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_r;
  logic              push;
  logic              pop;
  logic              flush_hit;

  assign out_valid = (state != EMPTY);
  // With a skid entry, ready comes straight from a flop; without one it must
  // look at the downstream ready to keep full throughput.
  assign in_ready  = (SKID != 0) ? in_ready_r : (!out_valid || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = occ_of(state);
  assign flush_hit = FLUSH && (state != EMPTY);

  always_ff @(negedge CLK) begin
    if (RST) begin
      state      <= EMPTY;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      in_ready_r <= 1'b1;
    end else if (FLUSH) begin
      // Data is left in place; cleared control bits make the entries bubbles.
      state      <= EMPTY;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_r <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (push) begin
            if (SKID != 0) begin
              skid_data  <= in_data;
              skid_ctrl  <= in_ctrl;
              state      <= FULL;
              in_ready_r <= 1'b0;
            end
          end else if (pop) begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_ctrl  <= '0;
            state      <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          main_ctrl  <= '0;
          skid_ctrl  <= '0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .CLK   (CLK),
    .clr   (RST),
    .inc   (flush_hit),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances (skid, no skid, 2-bit counter)
// share stimulus; each scenario task checks the instance it targets.
module tb_pipe_stage_buf;

  localparam int DW = 101;
  localparam int CW = 7;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic          FLUSH;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [1:0]    a_occ;
  logic [15:0]   a_fcnt;

  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [1:0]    b_occ;
  logic [15:0]   b_fcnt;

  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [CW-1:0] c_out_ctrl;
  logic [1:0]    c_occ;
  logic [1:0]    c_fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ), .flush_cnt(a_fcnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occ), .flush_cnt(b_fcnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(2)) dut_c (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_ctrl(c_out_ctrl), .occupancy(c_occ), .flush_cnt(c_fcnt)
  );

  // Inputs change on the rising edge; the design samples on the falling edge.
  task automatic step();
    @(posedge CLK);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    FLUSH     = f;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== 7'h00) begin n_fail++; $display("FAIL reset_out_ctrl: got %h expected 00", a_out_ctrl); end
    n_checks++; if (a_out_data !== 101'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", a_out_data); end
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", a_occ); end
    n_checks++; if (a_fcnt !== 16'd0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", a_fcnt); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_skid: got %b expected 1", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_noskid: got %b expected 1", b_in_ready); end
    RST = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL fill_occ0: got %0d expected 0", a_occ); end
    drive(1'b1, 101'h11, 7'h15, 1'b1, 1'b0);
    step();
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid: got %b expected 1", a_out_valid); end
    n_checks++; if (a_out_data !== 101'h11) begin n_fail++; $display("FAIL fill_out_data: got %h expected 11", a_out_data); end
    n_checks++; if (a_out_ctrl !== 7'h15) begin n_fail++; $display("FAIL fill_out_ctrl: got %h expected 15", a_out_ctrl); end
    n_checks++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL fill_occ1: got %0d expected 1", a_occ); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL fill_occ_drain: got %0d expected 0", a_occ); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid_drain: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== 7'h00) begin n_fail++; $display("FAIL fill_ctrl_bubble: got %h expected 00", a_out_ctrl); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 101'hA1, 7'h01, 1'b0, 1'b0);
    step();
    n_checks++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ_a: got %0d expected 1", a_occ); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %b expected 1", a_in_ready); end
    drive(1'b1, 101'hB2, 7'h02, 1'b0, 1'b0);
    step();
    n_checks++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d expected 2", a_occ); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", a_in_ready); end
    n_checks++; if (a_out_data !== 101'hA1) begin n_fail++; $display("FAIL bp_head_a: got %h expected A1", a_out_data); end
    drive(1'b1, 101'hC3, 7'h04, 1'b0, 1'b0);
    step();
    n_checks++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_hold: got %0d expected 2", a_occ); end
    n_checks++; if (a_out_data !== 101'hA1) begin n_fail++; $display("FAIL bp_head_hold: got %h expected A1", a_out_data); end
    drive(1'b1, 101'hC3, 7'h04, 1'b1, 1'b0);
    step();
    n_checks++; if (a_out_data !== 101'hB2) begin n_fail++; $display("FAIL bp_head_b: got %h expected B2", a_out_data); end
    n_checks++; if (a_out_ctrl !== 7'h02) begin n_fail++; $display("FAIL bp_ctrl_b: got %h expected 02", a_out_ctrl); end
    n_checks++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ_b: got %0d expected 1", a_occ); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b: got %b expected 1", a_in_ready); end
    step();
    n_checks++; if (a_out_data !== 101'hC3) begin n_fail++; $display("FAIL bp_head_c: got %h expected C3", a_out_data); end
    n_checks++; if (a_out_ctrl !== 7'h04) begin n_fail++; $display("FAIL bp_ctrl_c: got %h expected 04", a_out_ctrl); end
    n_checks++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ_c: got %0d expected 1", a_occ); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL bp_occ_end: got %0d expected 0", a_occ); end
    n_checks++; if (a_out_ctrl !== 7'h00) begin n_fail++; $display("FAIL bp_ctrl_end: got %h expected 00", a_out_ctrl); end
  endtask

  task automatic test_flush_push();
    do_reset();
    drive(1'b1, 101'hA1, 7'h01, 1'b0, 1'b0);
    step();
    drive(1'b1, 101'hB2, 7'h02, 1'b0, 1'b0);
    step();
    n_checks++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL fp_occ_pre: got %0d expected 2", a_occ); end
    drive(1'b1, 101'hDD, 7'h7F, 1'b0, 1'b1);
    step();
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL fp_occ: got %0d expected 0", a_occ); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== 7'h00) begin n_fail++; $display("FAIL fp_ctrl: got %h expected 00", a_out_ctrl); end
    n_checks++; if (a_fcnt !== 16'd1) begin n_fail++; $display("FAIL fp_flush_cnt: got %0d expected 1", a_fcnt); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fp_in_ready: got %b expected 1", a_in_ready); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_dropped_beat: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_flush_empty();
    do_reset();
    drive(1'b1, 101'h44, 7'h08, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    step();
    n_checks++; if (a_fcnt !== 16'd1) begin n_fail++; $display("FAIL fe_cnt_pop: got %0d expected 1", a_fcnt); end
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL fe_occ: got %0d expected 0", a_occ); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    n_checks++; if (a_fcnt !== 16'd1) begin n_fail++; $display("FAIL fe_cnt_empty: got %0d expected 1", a_fcnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    n_checks++; if (a_fcnt !== 16'd1) begin n_fail++; $display("FAIL fe_cnt_empty2: got %0d expected 1", a_fcnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(8'h50 + i), 7'h01, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step();
      n_checks++;
      if (c_fcnt !== exp_cnt[i]) begin
        n_fail++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, c_fcnt, exp_cnt[i]);
      end
    end
    n_checks++; if (a_fcnt !== 16'd5) begin n_fail++; $display("FAIL sat_wide_cnt: got %0d expected 5", a_fcnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_skid0_stream();
    logic          rdy   [6];
    logic          vld   [6];
    logic [DW-1:0] din   [6];
    logic          exp_v [6];
    logic [DW-1:0] exp_d [6];
    logic          exp_r [6];
    logic [DW-1:0] got   [$];
    rdy   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vld   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    din   = '{101'h30, 101'h31, 101'h32, 101'h32, 101'h33, 101'h0};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_d = '{101'h0, 101'h30, 101'h31, 101'h31, 101'h32, 101'h33};
    exp_r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (b_out_valid !== exp_v[k]) begin
        n_fail++; $display("FAIL s0_valid_%0d: got %b expected %b", k, b_out_valid, exp_v[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (b_out_data !== exp_d[k]) begin
          n_fail++; $display("FAIL s0_data_%0d: got %h expected %h", k, b_out_data, exp_d[k]);
        end
      end
      drive(vld[k], din[k], 7'h03, rdy[k], 1'b0);
      #1;
      n_checks++;
      if (b_in_ready !== exp_r[k]) begin
        n_fail++; $display("FAIL s0_in_ready_%0d: got %b expected %b", k, b_in_ready, exp_r[k]);
      end
      if (b_out_valid === 1'b1 && rdy[k]) got.push_back(b_out_data);
      step();
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL s0_beat_count: got %0d expected 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (got[j] !== DW'(8'h30 + j)) begin
          n_fail++; $display("FAIL s0_order_%0d: got %h expected %h", j, got[j], DW'(8'h30 + j));
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 101'h61, 7'h01, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b1, 101'h62, 7'h02, 1'b0, 1'b0);
    step();
    drive(1'b1, 101'h63, 7'h04, 1'b0, 1'b0);
    step();
    n_checks++; if (a_fcnt !== 16'd1) begin n_fail++; $display("FAIL rm_cnt_pre: got %0d expected 1", a_fcnt); end
    n_checks++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL rm_occ_pre: got %0d expected 2", a_occ); end
    RST = 1'b1;
    drive(1'b1, 101'h64, 7'h08, 1'b1, 1'b1);
    step();
    RST = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL rm_occ: got %0d expected 0", a_occ); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== 7'h00) begin n_fail++; $display("FAIL rm_ctrl: got %h expected 00", a_out_ctrl); end
    n_checks++; if (a_out_data !== 101'h0) begin n_fail++; $display("FAIL rm_data: got %h expected 0", a_out_data); end
    n_checks++; if (a_fcnt !== 16'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d expected 0", a_fcnt); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b expected 1", a_in_ready); end
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_fill();
    test_backpressure();
    test_flush_push();
    test_flush_empty();
    test_saturation();
    test_skid0_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
